// File: rtl/neighbor_pkg.sv
// Shared types for the PE-to-PE neighbor partial-sum link.
// Entry layout is {value, row, column} in neighbor tile space.
package neighbor_pkg;

   localparam int NEIGHBOR_LANES = 8;
   localparam int NEIGHBOR_TILE = 128;
   localparam int VALUE_W = 8;
   localparam int COORD_W = $clog2(NEIGHBOR_TILE);
   localparam int ENTRY_W = VALUE_W + 2 * COORD_W;

   typedef struct packed {
      logic [VALUE_W-1:0] value;
      logic [COORD_W-1:0] row;
      logic [COORD_W-1:0] column;
   } neighbor_entry_t;

endpackage

// File: rtl/valid_compactor.sv
// Packs valid lanes densely in ascending lane order.
// Purely combinational; dense_count is the number of valid lanes.
module valid_compactor
   import neighbor_pkg::*;
#(
   parameter int LANES = 16,
   localparam int IW = $clog2(LANES),
   localparam int NW = $clog2(LANES + 1)
) (
   input  neighbor_entry_t [LANES-1:0] lane_entry,
   input  logic [LANES-1:0]            lane_valid,
   output neighbor_entry_t [LANES-1:0] dense_entry,
   output logic [NW-1:0]               dense_count
);

   logic [NW-1:0] slot;

   // running prefix count selects each valid lane's dense slot
   always_comb begin
      dense_entry = '0;
      slot = '0;
      for (int i = 0; i < LANES; i++) begin
         if (lane_valid[i]) begin
            dense_entry[slot[IW-1:0]] = lane_entry[i];
            slot = slot + 1'b1;
         end
      end
      dense_count = slot;
   end

endmodule

// File: rtl/neighbor_output_processor.sv
// Sender side of the neighbor link: halo product FIFO that
// drains up to 8 entries per cycle to the adjacent PE.
module neighbor_output_processor
   import neighbor_pkg::*;
#(
   parameter int PRODUCT_COUNT = 16,
   parameter int TILE_SIZE = 128,
   parameter int FIFO_DEPTH = 64,
   localparam int CW = $clog2(TILE_SIZE),
   localparam int AW = $clog2(FIFO_DEPTH),
   localparam int PW = $clog2(PRODUCT_COUNT + 1),
   localparam int LW = $clog2(NEIGHBOR_LANES + 1)
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [PRODUCT_COUNT-1:0][7:0]  product_value,
   input  logic [PRODUCT_COUNT-1:0][CW-1:0] product_row,
   input  logic [PRODUCT_COUNT-1:0][CW-1:0] product_column,
   input  logic [PRODUCT_COUNT-1:0]       product_valid,
   input  logic                           neighbor_busy,
   output logic [NEIGHBOR_LANES-1:0][7:0] neighbor_output_value,
   output logic [NEIGHBOR_LANES-1:0][CW-1:0] neighbor_output_row,
   output logic [NEIGHBOR_LANES-1:0][CW-1:0] neighbor_output_column,
   output logic [NEIGHBOR_LANES-1:0]      neighbor_output_write_enable,
   output logic                           stall,
   output logic [AW:0]                    occupancy
);

   neighbor_entry_t [PRODUCT_COUNT-1:0] lane_entry;
   neighbor_entry_t [PRODUCT_COUNT-1:0] dense_entry;
   logic [PW-1:0]   push_count;
   logic [PW-1:0]   pushed;
   logic [LW-1:0]   avail;
   logic [LW-1:0]   popped;

   neighbor_entry_t mem [FIFO_DEPTH];
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;
   logic [AW:0]     count;
   logic [AW:0]     count_next;
   neighbor_entry_t out_entry;

   // bundle the per-lane product fields into entries
   always_comb begin
      for (int i = 0; i < PRODUCT_COUNT; i++) begin
         lane_entry[i].value  = product_value[i];
         lane_entry[i].row    = product_row[i];
         lane_entry[i].column = product_column[i];
      end
   end

   valid_compactor #(
      .LANES(PRODUCT_COUNT)
   ) u_compactor (
      .lane_entry (lane_entry),
      .lane_valid (product_valid),
      .dense_entry(dense_entry),
      .dense_count(push_count)
   );

   // push/pop amounts and next count; stall blocks all pushes
   always_comb begin
      if (count >= (AW+1)'(NEIGHBOR_LANES))
         avail = LW'(NEIGHBOR_LANES);
      else
         avail = count[LW-1:0];
      popped = neighbor_busy ? '0 : avail;
      pushed = stall ? '0 : push_count;
      count_next = count + (AW+1)'(pushed) - (AW+1)'(popped);
   end

   // present the oldest avail entries; unused lanes stay zero
   always_comb begin
      for (int j = 0; j < NEIGHBOR_LANES; j++) begin
         if (LW'(j) < avail)
            out_entry = mem[rd_ptr + AW'(j)];
         else
            out_entry = '0;
         neighbor_output_value[j]  = out_entry.value;
         neighbor_output_row[j]    = out_entry.row;
         neighbor_output_column[j] = out_entry.column;
         neighbor_output_write_enable[j] =
            (LW'(j) < avail) && !neighbor_busy;
      end
   end

   // pointer, count and stall state
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         stall  <= 1'b0;
      end else begin
         rd_ptr <= rd_ptr + AW'(popped);
         wr_ptr <= wr_ptr + AW'(pushed);
         count  <= count_next;
         stall  <= count_next >
                   (AW+1)'(FIFO_DEPTH - PRODUCT_COUNT);
      end
   end

   // storage write of the compacted lanes at the write pointer
   always_ff @(posedge clk) begin
      if (!reset && !stall) begin
         for (int i = 0; i < PRODUCT_COUNT; i++) begin
            if (PW'(i) < push_count)
               mem[wr_ptr + AW'(i)] <= dense_entry[i];
         end
      end
   end

   assign occupancy = count;

endmodule

// File: tb/tb_neighbor_output_processor.sv
// Directed bench for neighbor_output_processor with an
// arrival-order scoreboard checked every cycle.
module tb_neighbor_output_processor;
   import neighbor_pkg::*;

   localparam int PC = 16;
   localparam int CW = 7;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic neighbor_busy = 1'b0;
   logic [PC-1:0][7:0]    product_value;
   logic [PC-1:0][CW-1:0] product_row;
   logic [PC-1:0][CW-1:0] product_column;
   logic [PC-1:0]         product_valid;
   logic [7:0][7:0]       nv;
   logic [7:0][CW-1:0]    nr;
   logic [7:0][CW-1:0]    nc;
   logic [7:0]            nwe;
   logic                  stall;
   logic [6:0]            occupancy;

   int checks = 0;
   int errors = 0;
   bit armed = 1'b0;
   neighbor_entry_t q[$];

   always #5 clk = ~clk;

   neighbor_output_processor dut (
      .clk                         (clk),
      .reset                       (reset),
      .product_value               (product_value),
      .product_row                 (product_row),
      .product_column              (product_column),
      .product_valid               (product_valid),
      .neighbor_busy               (neighbor_busy),
      .neighbor_output_value       (nv),
      .neighbor_output_row         (nr),
      .neighbor_output_column      (nc),
      .neighbor_output_write_enable(nwe),
      .stall                       (stall),
      .occupancy                   (occupancy)
   );

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic clear_inputs();
      product_valid  = '0;
      product_value  = '0;
      product_row    = '0;
      product_column = '0;
   endtask

   task automatic set_lane(input int i, input logic [7:0] v,
                           input logic [6:0] r,
                           input logic [6:0] c);
      product_valid[i]  = 1'b1;
      product_value[i]  = v;
      product_row[i]    = r;
      product_column[i] = c;
   endtask

   // check outputs at negedge against the queue, then advance it
   task automatic step(output bit accepted);
      logic [7:0][7:0]    ev;
      logic [7:0][CW-1:0] er;
      logic [7:0][CW-1:0] ec;
      logic [7:0]         ew;
      int n;
      bit exp_stall;
      @(negedge clk);
      n = (q.size() < 8) ? q.size() : 8;
      ev = '0;
      er = '0;
      ec = '0;
      ew = '0;
      for (int j = 0; j < n; j++) begin
         ev[j] = q[j].value;
         er[j] = q[j].row;
         ec[j] = q[j].column;
         ew[j] = !neighbor_busy;
      end
      exp_stall = q.size() > 48;
      if (armed) begin
         check("we", 64'(nwe), 64'(ew));
         check("value", 64'(nv), 64'(ev));
         check("row", 64'(nr), 64'(er));
         check("col", 64'(nc), 64'(ec));
         check("occ", 64'(occupancy), 64'(q.size()));
         check("stall", 64'(stall), 64'(exp_stall));
      end
      accepted = 1'b0;
      if (reset) begin
         q.delete();
         armed = 1'b1;
      end else begin
         if (!neighbor_busy)
            for (int k = 0; k < n; k++) q.delete(0);
         if (!exp_stall) begin
            accepted = 1'b1;
            for (int i = 0; i < PC; i++)
               if (product_valid[i])
                  q.push_back('{product_value[i],
                                product_row[i],
                                product_column[i]});
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      bit acc;
      int seq;
      int guard;
      clear_inputs();

      step(acc);
      step(acc);
      check("rst_we", 64'(nwe), 64'h0);
      check("rst_stall", 64'(stall), 64'h0);
      check("rst_occ", 64'(occupancy), 64'h0);
      check("rst_val", 64'(nv), 64'h0);
      reset = 1'b0;

      set_lane(1, 8'h11, 7'd1, 7'd2);
      set_lane(4, 8'h22, 7'd4, 7'd5);
      set_lane(9, 8'h33, 7'd9, 7'd10);
      step(acc);
      clear_inputs();
      #1;
      check("t2_occ", 64'(occupancy), 64'd3);
      check("t2_we", 64'(nwe), 64'h07);
      check("t2_val", 64'(nv), 64'h0000_0000_0033_2211);
      check("t2_row", 64'(nr), 64'({7'd9, 7'd4, 7'd1}));
      check("t2_col", 64'(nc), 64'({7'd10, 7'd5, 7'd2}));
      step(acc);
      check("t2_drain", 64'(occupancy), 64'd0);

      seq = 0;
      for (int c = 0; c < 24; c++) begin
         for (int i = 0; i < PC; i++)
            set_lane(i, 8'(seq + i), 7'(seq + i), ~7'(seq + i));
         step(acc);
         if (acc) seq += 16;
         if (c < 6)
            check($sformatf("t3_occ%0d", c), 64'(occupancy),
                  64'(16 + 8 * c));
         if (c == 4) check("t3_nostall", 64'(stall), 64'd0);
         if (c == 5) check("t3_stall", 64'(stall), 64'd1);
      end
      clear_inputs();
      repeat (8) step(acc);
      check("t3_empty", 64'(occupancy), 64'd0);

      neighbor_busy = 1'b1;
      for (int i = 0; i < 5; i++)
         set_lane(i, 8'(8'hA0 + i), 7'(i), 7'(i + 1));
      step(acc);
      clear_inputs();
      repeat (5) begin
         step(acc);
         check("t4_occ5", 64'(occupancy), 64'd5);
         check("t4_we0", 64'(nwe), 64'h0);
      end
      neighbor_busy = 1'b0;
      #1;
      check("t4_we", 64'(nwe), 64'h1f);
      check("t4_val", 64'(nv), 64'h0000_00A4_A3A2_A1A0);
      step(acc);
      check("t4_occ0", 64'(occupancy), 64'd0);

      seq = 0;
      guard = 0;
      while (seq < 100 && guard < 200) begin
         clear_inputs();
         for (int i = 0; i < 7; i++)
            if (seq + i < 100)
               set_lane(2 * i, 8'(seq + i), 7'(i), 7'(seq + i));
         neighbor_busy = ($urandom_range(0, 3) == 0);
         step(acc);
         if (acc) seq += 7;
         guard++;
      end
      clear_inputs();
      neighbor_busy = 1'b0;
      repeat (20) step(acc);
      check("t5_empty", 64'(occupancy), 64'd0);

      neighbor_busy = 1'b1;
      for (int i = 0; i < PC; i++)
         set_lane(i, 8'(8'hC0 + i), 7'(i), 7'(i));
      step(acc);
      clear_inputs();
      for (int i = 0; i < 4; i++)
         set_lane(i, 8'(8'hE0 + i), 7'(i), 7'(i));
      step(acc);
      clear_inputs();
      check("t6_occ20", 64'(occupancy), 64'd20);
      reset = 1'b1;
      step(acc);
      reset = 1'b0;
      neighbor_busy = 1'b0;
      #1;
      check("t6_occ", 64'(occupancy), 64'd0);
      check("t6_we", 64'(nwe), 64'h0);
      check("t6_val", 64'(nv), 64'h0);
      repeat (4) step(acc);
      set_lane(3, 8'h5A, 7'd7, 7'd8);
      step(acc);
      clear_inputs();
      #1;
      check("t6_new_we", 64'(nwe), 64'h01);
      check("t6_new_val", 64'(nv), 64'h5A);
      step(acc);
      check("t6_final", 64'(occupancy), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/neighbor_output_processor.md
# neighbor_output_processor

Sender side of the PE-to-PE neighbor partial-sum link. It collects out-of-tile (halo) products flagged by the multiplier/crossbar stage, up to PRODUCT_COUNT per cycle, and queues them in a FIFO. It drains them to the adjacent PE's neighbor input port at up to 8 per cycle, honouring that receiver's busy (leftover) indication. It also back-pressures the upstream product stage when the FIFO is nearly full.

## Interface
- PRODUCT_COUNT, 16, product lanes accepted per cycle
- TILE_SIZE, 128, tile dimension; coordinate width is clog2(TILE_SIZE)
- FIFO_DEPTH, 64, queue entries; power of 2, at least PRODUCT_COUNT+8
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- product_value  in  8 x PRODUCT_COUNT  halo product data
- product_row  in  clog2(TILE_SIZE) x PRODUCT_COUNT  destination row in neighbor tile space
- product_column  in  clog2(TILE_SIZE) x PRODUCT_COUNT  destination column in neighbor tile space
- product_valid  in  PRODUCT_COUNT  per-lane valid
- neighbor_busy  in  1  receiver's leftover_inputs; while high the receiver ignores its inputs
- neighbor_output_value  out  8 x 8  lane data to neighbor
- neighbor_output_row  out  clog2(TILE_SIZE) x 8  lane row
- neighbor_output_column  out  clog2(TILE_SIZE) x 8  lane column
- neighbor_output_write_enable  out  8  per-lane enable
- stall  out  1  registered; while high, product inputs are ignored and upstream must hold them
- occupancy  out  clog2(FIFO_DEPTH)+1  registered entry count

## Operation
- Entry = {value, row, column}. FIFO storage is registered, with read pointer, write pointer and count.
- Push (stall low):
  - valid lanes are compacted in ascending lane index order and written at the write pointer;
  - k valid lanes add k entries;
  - invalid lanes are dropped.
- Push while stall is high: inputs are ignored entirely and nothing is written.
- Pop: avail = min(8, count), using count at the start of the cycle.
  - Output lane j (j < avail) presents entry at read pointer + j.
  - Lanes j >= avail drive value/row/column = 0.
- Enables: write_enable[j] = (j < avail) AND NOT neighbor_busy. This is the only combinational input-to-output path.
- At the clock edge with neighbor_busy low, the read pointer advances by avail and count drops by avail. With neighbor_busy high, nothing pops.
- Same-cycle push and pop:
  - count_next = count + pushed − popped;
  - entries pushed this cycle are not eligible to pop until the next cycle.
- Ordering: entries leave strictly in arrival order (cycle first, then lane index). No loss, no duplication.
- Pointers wrap modulo FIFO_DEPTH. Arithmetic is unsigned.
- stall_next = (count_next > FIFO_DEPTH − PRODUCT_COUNT). Overflow is therefore impossible by construction.
- Reset, including mid-operation, clears:
  - pointers, count, occupancy = 0;
  - stall = 0;
  - all write_enable = 0 and all output data = 0 from the next cycle.
  - Stale entries must never appear on the outputs.

## Timing
- Product accepted at edge t appears with enable asserted in the cycle after t, if neighbor_busy is low then. Minimum latency is 1 cycle.
- neighbor_busy gates enables in the same cycle; the receiver sees no enable while it is busy.
- stall and occupancy reflect the state after edge t, in the cycle following t.
- Sustained throughput is 8 entries/cycle out; input bursts above 8/cycle are absorbed by the FIFO until stall asserts.

## Structure
- Shared package neighbor_pkg:
  - NEIGHBOR_LANES = 8;
  - entry width constant (8 + 2·clog2(TILE_SIZE) for TILE_SIZE = 128);
  - neighbor_entry_t packed struct {value, row, column}.
- Sub-module valid_compactor: prefix-count compaction of PRODUCT_COUNT lanes into a dense list plus a count. It is combinational, instantiated once.

## Test plan
- Reset held 2 cycles -> write_enable = 0, stall = 0, occupancy = 0, output data = 0.
- Lanes 1, 4, 9 valid with values 0x11, 0x22, 0x33, neighbor_busy low -> next cycle lanes 0–2 enabled with 0x11, 0x22, 0x33 and correct coordinates; occupancy 3 then 0.
- 16 valid/cycle continuously, busy low, depth 64 -> occupancy 16, 24, 32, 40, 48, 56; stall asserts after count exceeds 48. Output sequence is in exact input order with no gaps.
- 5 entries queued, neighbor_busy high 5 cycles -> enables 0 and occupancy 5 throughout. Busy drops -> lanes 0–4 enabled that same cycle, occupancy 0 next.
- Push 100 sequentially numbered entries across pointer wrap -> output values appear in 0..99 order.
- Reset asserted with occupancy 20 -> next cycle occupancy 0, no enables; none of those 20 entries is ever emitted.
